// File: rtl/destruct_stream.sv
// Wide-to-narrow gearbox: splits ISIZE-bit beats into OSIZE-bit words, MSB-first,
// with end-of-line flush (byte-masked partial word) and a synchronous re-align.
module destruct_stream #(
    parameter int unsigned ISIZE = 256,
    parameter int unsigned OSIZE = 24
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               ialign,
    input  logic               ivalid,
    output logic               iready,
    input  logic [ISIZE-1:0]   idata,
    input  logic               ilast,
    output logic               ovalid,
    input  logic               oready,
    output logic [OSIZE-1:0]   odata,
    output logic [OSIZE/8-1:0] omask,
    output logic               olast
);

    localparam int unsigned BW = ISIZE + OSIZE;
    localparam int unsigned CW = $clog2(ISIZE + OSIZE) + 1;
    localparam int unsigned MW = OSIZE / 8;

    localparam logic [CW-1:0] OSZ  = CW'(OSIZE);
    localparam logic [CW-1:0] OSZ2 = CW'(2 * OSIZE);
    localparam logic [CW-1:0] ISZ  = CW'(ISIZE);

    // Left-aligned bit buffer; bits below cnt are always kept zero.
    logic [BW-1:0] sbuf_q, sbuf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_pend_q, last_pend_d;

    logic          full;
    logic          pop;
    logic          push;
    logic [BW-1:0] buf_pop;
    logic [CW-1:0] cnt_pop;

    // Handshake and output decode from registered state (iready also looks at oready).
    always_comb begin
        full   = (cnt_q >= OSZ);
        ovalid = !ialign && (full || (last_pend_q && (cnt_q != '0)));
        olast  = ovalid && last_pend_q && (cnt_q <= OSZ);
        pop    = ovalid && oready;
        // A pop this cycle frees room, so a beat can land without a bubble.
        iready = !ialign && !last_pend_q && (!full || ((cnt_q < OSZ2) && pop));
        push   = ivalid && iready;

        odata = sbuf_q[BW-1 -: OSIZE];
        omask = '0;
        for (int i = 0; i < OSIZE; i++) begin
            if (!full && (CW'(i) >= cnt_q)) begin
                odata[OSIZE-1-i] = 1'b0;
            end
        end
        if (ovalid) begin
            for (int i = 0; i < MW; i++) begin
                omask[MW-1-i] = full || (CW'(8 * i + 8) <= cnt_q);
            end
        end
    end

    // Next state: pop shift first, then the new beat goes directly below the survivors.
    always_comb begin
        buf_pop     = pop ? (sbuf_q << OSIZE) : sbuf_q;
        cnt_pop     = cnt_q;
        if (pop) begin
            cnt_pop = full ? (cnt_q - OSZ) : '0;
        end
        sbuf_d      = buf_pop;
        cnt_d       = cnt_pop;
        last_pend_d = last_pend_q;
        if (pop && olast) begin
            last_pend_d = 1'b0;
        end
        if (push) begin
            sbuf_d = buf_pop | ({idata, {OSIZE{1'b0}}} >> cnt_pop);
            cnt_d  = cnt_pop + ISZ;
            if (ilast) begin
                last_pend_d = 1'b1;
            end
        end
        // Clearing the buffer keeps the zero-below-cnt invariant after a re-align.
        if (ialign) begin
            sbuf_d      = '0;
            cnt_d       = '0;
            last_pend_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sbuf_q      <= '0;
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
        end else begin
            sbuf_q      <= sbuf_d;
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
        end
    end

endmodule
